// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Constants shared by the MIPS controller and the ALU: datapath width and
// the 3-bit ALU operation encodings.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [2:0] ALU_OP_ADD  = 3'd0;
    localparam logic [2:0] ALU_OP_SUB  = 3'd1;
    localparam logic [2:0] ALU_OP_AND  = 3'd2;
    localparam logic [2:0] ALU_OP_OR   = 3'd3;
    localparam logic [2:0] ALU_OP_LESS = 3'd4;
    localparam logic [2:0] ALU_OP_B    = 3'd5;
    localparam logic [2:0] ALU_OP_SLL  = 3'd6;
    localparam logic [2:0] ALU_OP_SRL  = 3'd7;

endpackage

// File: rtl/alu_addsub.sv
// ---------------------------------------------------------------------------
// alu_addsub
// 32-bit adder with a subtract control, shared by ADD and SUB.
// Ports:
//   i_a, i_b  operands
//   i_sub     1 = i_a - i_b, 0 = i_a + i_b
//   o_sum     result mod 2^32
//   o_ovf     signed overflow of the selected operation
// ---------------------------------------------------------------------------
module alu_addsub
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] i_a,
    input  logic [ALU_W-1:0] i_b,
    input  logic             i_sub,
    output logic [ALU_W-1:0] o_sum,
    output logic             o_ovf
);

    logic [ALU_W-1:0] w_b_eff;

    // Subtraction as a + ~b + 1; the carry-in supplies the +1.
    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign o_sum   = i_a + w_b_eff + {{(ALU_W-1){1'b0}}, i_sub};

    // Overflow on the effective addition: same-sign inputs, different-sign
    // result. For SUB this reduces to "x, y signs differ and result sign
    // differs from x" because w_b_eff carries the inverted sign of y.
    assign o_ovf = (i_a[ALU_W-1] == w_b_eff[ALU_W-1]) &&
                   (o_sum[ALU_W-1] != i_a[ALU_W-1]);

endmodule

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Combinational 32-bit ALU for the single-cycle MIPS datapath, plus a
// sticky overflow status bit for exception/debug observation.
// Ports:
//   clk, rst    clock and synchronous active-high reset (sticky bit only)
//   x, y        operands; y is the shifted operand for SLL/SRL
//   ALUOp       operation select (ALU_OP_* in alu_pkg)
//   shamt       shift amount; bit 5 set forces a zero shift result
//   ALUOut      result (combinational)
//   zero        ALUOut == 0 (combinational)
//   flag        status word, bit 0 = signed overflow (combinational)
//   ovf_sticky  OR of flag[0] over all edges since reset
// ---------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ALU_W-1:0] x,
    input  logic [ALU_W-1:0] y,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       shamt,
    output logic [ALU_W-1:0] ALUOut,
    output logic             zero,
    output logic [ALU_W-1:0] flag,
    output logic             ovf_sticky
);

    logic [ALU_W-1:0] w_sum;
    logic             w_as_ovf;
    logic             w_ovf;
    logic [ALU_W-1:0] w_result;
    logic             r_ovf_sticky;

    alu_addsub u_addsub (
        .i_a   (x),
        .i_b   (y),
        .i_sub (ALUOp == ALU_OP_SUB),
        .o_sum (w_sum),
        .o_ovf (w_as_ovf)
    );

    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        case (ALUOp)
            ALU_OP_ADD: begin
                w_result = w_sum;
                w_ovf    = w_as_ovf;
            end
            ALU_OP_SUB: begin
                w_result = w_sum;
                w_ovf    = w_as_ovf;
            end
            ALU_OP_AND:  w_result = x & y;
            ALU_OP_OR:   w_result = x | y;
            // True signed compare, not derived from the subtractor, so it
            // stays correct when x - y would overflow.
            ALU_OP_LESS: w_result = {{(ALU_W-1){1'b0}}, ($signed(x) < $signed(y))};
            ALU_OP_B:    w_result = y;
            ALU_OP_SLL:  w_result = shamt[5] ? '0 : (y << shamt[4:0]);
            ALU_OP_SRL:  w_result = shamt[5] ? '0 : (y >> shamt[4:0]);
            default:     w_result = '0;
        endcase
    end

    assign ALUOut = w_result;
    assign zero   = (w_result == '0);
    assign flag   = {{(ALU_W-1){1'b0}}, w_ovf};

    // Reset has priority over a same-cycle overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
        end else begin
            r_ovf_sticky <= r_ovf_sticky | w_ovf;
        end
    end

    assign ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_alu.sv
module tb_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x, y;
    logic [2:0]  ALUOp;
    logic [5:0]  shamt;
    logic [31:0] ALUOut;
    logic        zero;
    logic [31:0] flag;
    logic        ovf_sticky;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .y          (y),
        .ALUOp      (ALUOp),
        .shamt      (shamt),
        .ALUOut     (ALUOut),
        .zero       (zero),
        .flag       (flag),
        .ovf_sticky (ovf_sticky)
    );

    // Reference model: plain wide signed arithmetic on the spec's rules.
    function automatic void model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [5:0] sh,
                                  output logic [31:0] res, output logic ovf);
        longint sa, sb, s;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = 32'd0;
        ovf = 1'b0;
        case (op)
            3'd0: begin s = sa + sb; res = s[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'd1: begin s = sa - sb; res = s[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = (sa < sb) ? 32'd1 : 32'd0;
            3'd5: res = b;
            3'd6: res = (sh >= 6'd32) ? 32'd0 : (b << sh);
            3'd7: res = (sh >= 6'd32) ? 32'd0 : (b >> sh);
            default: res = 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] sh);
        @(negedge clk);
        ALUOp = op; x = a; y = b; shamt = sh;
        #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  sh;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    task automatic test_reset();
        rst = 1'b1;
        drive(ALU_OP_ADD, 32'd100, 32'd200, 6'd0);
        // combinational path unaffected by reset
        checks++;
        if (ALUOut !== 32'd300) begin
            failures++;
            $display("FAIL reset_comb_out actual=%h expected=%h", ALUOut, 32'd300);
        end
        @(posedge clk); #1;
        checks++;
        if (ovf_sticky !== 1'b0) begin
            failures++;
            $display("FAIL reset_sticky actual=%b expected=0", ovf_sticky);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        vec_t v[$];
        v.push_back('{ALU_OP_SUB,  32'd300,        32'd300,        6'd0,  32'd0,          1'b0});
        v.push_back('{ALU_OP_ADD,  32'd100,        32'd200,        6'd0,  32'd300,        1'b0});
        v.push_back('{ALU_OP_ADD,  32'h7fffffff,   32'd1,          6'd0,  32'h80000000,   1'b1});
        v.push_back('{ALU_OP_SUB,  32'd100,        32'd200,        6'd0,  32'hffffff9c,   1'b0});
        v.push_back('{ALU_OP_SUB,  32'h70000000,   32'h90000000,   6'd0,  32'he0000000,   1'b1});
        v.push_back('{ALU_OP_AND,  32'd100,        32'd200,        6'd0,  32'h40,         1'b0});
        v.push_back('{ALU_OP_OR,   32'd100,        32'd200,        6'd0,  32'hec,         1'b0});
        v.push_back('{ALU_OP_LESS, 32'd100,        32'd200,        6'd0,  32'd1,          1'b0});
        v.push_back('{ALU_OP_LESS, 32'hffffffff,   32'd1,          6'd0,  32'd1,          1'b0});
        v.push_back('{ALU_OP_LESS, 32'h7fffffff,   32'h80000000,   6'd0,  32'd0,          1'b0});
        v.push_back('{ALU_OP_B,    32'hdeadbeef,   32'd200,        6'd0,  32'd200,        1'b0});
        v.push_back('{ALU_OP_SLL,  32'hdeadbeef,   32'd1,          6'd4,  32'h10,         1'b0});
        v.push_back('{ALU_OP_SRL,  32'd0,          32'h80000000,   6'd31, 32'd1,          1'b0});
        v.push_back('{ALU_OP_SLL,  32'd0,          32'hffffffff,   6'd32, 32'd0,          1'b0});
        v.push_back('{ALU_OP_SRL,  32'd0,          32'hffffffff,   6'd63, 32'd0,          1'b0});
        v.push_back('{ALU_OP_SRL,  32'd0,          32'hffffffff,   6'd0,  32'hffffffff,   1'b0});
        v.push_back('{ALU_OP_ADD,  32'h80000000,   32'h80000000,   6'd0,  32'd0,          1'b1});
        v.push_back('{ALU_OP_SUB,  32'd0,          32'h80000000,   6'd0,  32'h80000000,   1'b1});
        foreach (v[i]) begin
            drive(v[i].op, v[i].a, v[i].b, v[i].sh);
            checks++;
            if (ALUOut !== v[i].res) begin
                failures++;
                $display("FAIL dir%0d_out op=%0d actual=%h expected=%h", i, v[i].op, ALUOut, v[i].res);
            end
            checks++;
            if (zero !== (v[i].res == 32'd0)) begin
                failures++;
                $display("FAIL dir%0d_zero actual=%b expected=%b", i, zero, (v[i].res == 32'd0));
            end
            checks++;
            if (flag !== {31'd0, v[i].ovf}) begin
                failures++;
                $display("FAIL dir%0d_flag actual=%h expected=%h", i, flag, {31'd0, v[i].ovf});
            end
        end
    endtask

    task automatic test_sticky();
        rst = 1'b0;
        drive(ALU_OP_SUB, 32'h70000000, 32'h90000000, 6'd0);
        @(posedge clk); #1;
        checks++;
        if (ovf_sticky !== 1'b1) begin
            failures++;
            $display("FAIL sticky_set actual=%b expected=1", ovf_sticky);
        end
        drive(ALU_OP_ADD, 32'd1, 32'd2, 6'd0);
        @(posedge clk); #1;
        checks++;
        if (ovf_sticky !== 1'b1) begin
            failures++;
            $display("FAIL sticky_hold actual=%b expected=1", ovf_sticky);
        end
        // reset and overflow in the same cycle: reset wins
        drive(ALU_OP_ADD, 32'h7fffffff, 32'd1, 6'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ovf_sticky !== 1'b0) begin
            failures++;
            $display("FAIL sticky_rst_wins actual=%b expected=0", ovf_sticky);
        end
        rst = 1'b0;
        drive(ALU_OP_LESS, 32'h7fffffff, 32'h80000000, 6'd0);
        @(posedge clk); #1;
        checks++;
        if (ovf_sticky !== 1'b0) begin
            failures++;
            $display("FAIL sticky_no_ovf actual=%b expected=0", ovf_sticky);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] edges [6];
        edges = '{32'h0, 32'h1, 32'h7fffffff, 32'h80000000, 32'hffffffff, 32'h80000001};
        if ($urandom_range(3) == 0) return edges[$urandom_range(5)];
        return $urandom;
    endfunction

    task automatic test_random();
        logic        exp_sticky;
        logic [31:0] er;
        logic        eo;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [5:0]  sh;
        logic        do_rst;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_sticky = 1'b0;
        for (int n = 0; n < 400; n++) begin
            op = 3'($urandom_range(7));
            a  = pick_operand();
            b  = pick_operand();
            sh = 6'($urandom_range(63));
            do_rst = ($urandom_range(40) == 0);
            drive(op, a, b, sh);
            rst = do_rst;
            model(op, a, b, sh, er, eo);
            checks++;
            if (ALUOut !== er) begin
                failures++;
                $display("FAIL rnd%0d_out op=%0d x=%h y=%h sh=%0d actual=%h expected=%h", n, op, a, b, sh, ALUOut, er);
            end
            checks++;
            if (zero !== (er == 32'd0)) begin
                failures++;
                $display("FAIL rnd%0d_zero actual=%b expected=%b", n, zero, (er == 32'd0));
            end
            checks++;
            if (flag !== {31'd0, eo}) begin
                failures++;
                $display("FAIL rnd%0d_flag op=%0d x=%h y=%h actual=%h expected=%h", n, op, a, b, flag, {31'd0, eo});
            end
            @(posedge clk); #1;
            exp_sticky = do_rst ? 1'b0 : (exp_sticky | eo);
            checks++;
            if (ovf_sticky !== exp_sticky) begin
                failures++;
                $display("FAIL rnd%0d_sticky actual=%b expected=%b", n, ovf_sticky, exp_sticky);
            end
            rst = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; x = '0; y = '0; ALUOp = ALU_OP_ADD; shamt = '0;
        test_reset();
        test_directed();
        test_sticky();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
